temperature_observer_hub: RTL and testbench

TEMPERATURE_OBSERVER_HUB -- requirements
Module: temperature_observer_hub

---
 rtl/temperature_observer_hub_if.sv | 34 +++
 rtl/temperature_observer_hub.sv | 193 +++++++++++++++++++
 tb/tb_temperature_observer_hub.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/temperature_observer_hub_if.sv
// Command and notification bundle for temperature_observer_hub.
// The hub connects through the slave modport; the host/sink side uses master.
interface temperature_observer_hub_if #(
  parameter int unsigned NUM_OBS = 4,
  parameter int unsigned TEMP_W  = 8,
  parameter int unsigned ID_W    = 16
);
  localparam int unsigned CntW = $clog2(NUM_OBS + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ID_W-1:0]   cmd_id;
  logic [TEMP_W-1:0] cmd_data;
  logic              cmd_err;
  logic              busy;
  logic [CntW-1:0]   obs_count;
  logic [TEMP_W-1:0] cur_temp;
  logic              ntf_valid;
  logic              ntf_ready;
  logic [ID_W-1:0]   ntf_id;
  logic [1:0]        ntf_kind;
  logic [TEMP_W-1:0] ntf_temp;

  modport master (
    output cmd_valid, cmd_op, cmd_id, cmd_data, ntf_ready,
    input  cmd_ready, cmd_err, busy, obs_count, cur_temp, ntf_valid, ntf_id, ntf_kind, ntf_temp
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_id, cmd_data, ntf_ready,
    output cmd_ready, cmd_err, busy, obs_count, cur_temp, ntf_valid, ntf_id, ntf_kind, ntf_temp
  );
endinterface

// File: rtl/temperature_observer_hub.sv
// Observer table of display/alarm slots; a set-temperature command sweeps all slots
// in index order and emits one handshaked notification per slot that needs one.
module temperature_observer_hub #(
  parameter int unsigned NUM_OBS = 4,
  parameter int unsigned TEMP_W  = 8,
  parameter int unsigned ID_W    = 16,
  parameter int unsigned HYST    = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  temperature_observer_hub_if.slave bus_io
);
  localparam int unsigned IdxW = $clog2(NUM_OBS);
  localparam int unsigned CntW = $clog2(NUM_OBS + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OBS - 1);

  localparam logic [1:0] OpAddDisp  = 2'b00;
  localparam logic [1:0] OpAddAlarm = 2'b01;
  localparam logic [1:0] OpRemove   = 2'b10;
  localparam logic [1:0] OpSet      = 2'b11;
  localparam logic [1:0] KindDisp   = 2'b00;
  localparam logic [1:0] KindRaise  = 2'b01;
  localparam logic [1:0] KindClear  = 2'b10;

  typedef enum logic [1:0] {StIdle, StScan, StEmit} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NUM_OBS-1:0] active_q, active_d, alarm_q, alarm_d, armed_q, armed_d;
  logic [ID_W-1:0]   id_q  [NUM_OBS];
  logic [ID_W-1:0]   id_d  [NUM_OBS];
  logic [TEMP_W-1:0] thr_q [NUM_OBS];
  logic [TEMP_W-1:0] thr_d [NUM_OBS];
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic              err_q, err_d;
  logic              ntf_valid_q, ntf_valid_d;
  logic [ID_W-1:0]   ntf_id_q, ntf_id_d;
  logic [1:0]        ntf_kind_q, ntf_kind_d;
  logic [TEMP_W-1:0] ntf_temp_q, ntf_temp_d;

  logic [NUM_OBS-1:0] hit;
  logic              any_hit, full;
  logic [IdxW-1:0]   hit_idx, free_idx;
  logic [CntW-1:0]   obs_cnt;
  logic [31:0]       thr_ext, clr_lvl;
  logic              raise, clear;

  // Descending loop so the lowest matching/free index wins.
  always_comb begin
    hit      = '0;
    hit_idx  = '0;
    free_idx = '0;
    full     = 1'b1;
    obs_cnt  = '0;
    for (int i = int'(NUM_OBS) - 1; i >= 0; i--) begin
      hit[i] = active_q[i] && (id_q[i] == bus_io.cmd_id);
      if (hit[i]) hit_idx = IdxW'(i);
      if (!active_q[i]) begin
        free_idx = IdxW'(i);
        full     = 1'b0;
      end
      obs_cnt = obs_cnt + CntW'(active_q[i]);
    end
  end

  assign any_hit = |hit;

  // Clear level is threshold minus hysteresis, floored at zero.
  always_comb begin
    thr_ext = 32'(thr_q[idx_q]);
    clr_lvl = (thr_ext > HYST) ? thr_ext - HYST : 32'd0;
    raise   = alarm_q[idx_q] && !armed_q[idx_q] && (temp_q >= thr_q[idx_q]);
    clear   = alarm_q[idx_q] && armed_q[idx_q] && (32'(temp_q) < clr_lvl);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    active_d    = active_q;
    alarm_d     = alarm_q;
    armed_d     = armed_q;
    id_d        = id_q;
    thr_d       = thr_q;
    temp_d      = temp_q;
    err_d       = 1'b0;
    ntf_valid_d = ntf_valid_q;
    ntf_id_d    = ntf_id_q;
    ntf_kind_d  = ntf_kind_q;
    ntf_temp_d  = ntf_temp_q;
    case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          case (bus_io.cmd_op)
            OpAddDisp, OpAddAlarm: begin
              if (full || any_hit) begin
                err_d = 1'b1;
              end else begin
                active_d[free_idx] = 1'b1;
                alarm_d[free_idx]  = (bus_io.cmd_op == OpAddAlarm);
                armed_d[free_idx]  = 1'b0;
                id_d[free_idx]     = bus_io.cmd_id;
                thr_d[free_idx]    = bus_io.cmd_data;
              end
            end
            OpRemove: begin
              if (any_hit) begin
                active_d[hit_idx] = 1'b0;
                armed_d[hit_idx]  = 1'b0;
              end else begin
                err_d = 1'b1;
              end
            end
            OpSet: begin
              temp_d  = bus_io.cmd_data;
              idx_d   = '0;
              state_d = StScan;
            end
            default: ;
          endcase
        end
      end
      StScan: begin
        if (active_q[idx_q] && (!alarm_q[idx_q] || raise || clear)) begin
          ntf_valid_d = 1'b1;
          ntf_id_d    = id_q[idx_q];
          ntf_temp_d  = temp_q;
          ntf_kind_d  = !alarm_q[idx_q] ? KindDisp : (raise ? KindRaise : KindClear);
          if (raise) armed_d[idx_q] = 1'b1;
          if (clear) armed_d[idx_q] = 1'b0;
          state_d = StEmit;
        end else if (idx_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StEmit: begin
        if (bus_io.ntf_ready) begin
          ntf_valid_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StScan;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      active_q    <= '0;
      alarm_q     <= '0;
      armed_q     <= '0;
      id_q        <= '{default: '0};
      thr_q       <= '{default: '0};
      temp_q      <= '0;
      err_q       <= 1'b0;
      ntf_valid_q <= 1'b0;
      ntf_id_q    <= '0;
      ntf_kind_q  <= '0;
      ntf_temp_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      alarm_q     <= alarm_d;
      armed_q     <= armed_d;
      id_q        <= id_d;
      thr_q       <= thr_d;
      temp_q      <= temp_d;
      err_q       <= err_d;
      ntf_valid_q <= ntf_valid_d;
      ntf_id_q    <= ntf_id_d;
      ntf_kind_q  <= ntf_kind_d;
      ntf_temp_q  <= ntf_temp_d;
    end
  end

  assign bus_io.cmd_ready = (state_q == StIdle);
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.cmd_err   = err_q;
  assign bus_io.obs_count = obs_cnt;
  assign bus_io.cur_temp  = temp_q;
  assign bus_io.ntf_valid = ntf_valid_q;
  assign bus_io.ntf_id    = ntf_id_q;
  assign bus_io.ntf_kind  = ntf_kind_q;
  assign bus_io.ntf_temp  = ntf_temp_q;
endmodule

// File: tb/tb_temperature_observer_hub.sv
// Bench for temperature_observer_hub: directed table, back-pressure and reset-in-EMIT
// sequences, then random commands checked against a transaction-level observer model.
module tb_temperature_observer_hub;
  localparam int unsigned N  = 4;
  localparam int unsigned TW = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned HY = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  temperature_observer_hub_if #(.NUM_OBS(N), .TEMP_W(TW), .ID_W(IW)) bus ();

  temperature_observer_hub #(.NUM_OBS(N), .TEMP_W(TW), .ID_W(IW), .HYST(HY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: observer list plus expected notification queue.
  typedef struct {int id; int kind; int temp;} ntf_t;
  bit    m_act[N];
  bit    m_alm[N];
  bit    m_arm[N];
  int    m_id[N];
  int    m_thr[N];
  int    m_temp;
  ntf_t  exp_q[$];

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_alm[i] = 0; m_arm[i] = 0; m_id[i] = 0; m_thr[i] = 0;
    end
    m_temp = 0;
    exp_q.delete();
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_act[i]);
    return c;
  endfunction

  function automatic bit m_add(input bit alarm, input int id, input int thr);
    for (int i = 0; i < N; i++) if (m_act[i] && m_id[i] == id) return 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!m_act[i]) begin
        m_act[i] = 1; m_alm[i] = alarm; m_arm[i] = 0; m_id[i] = id; m_thr[i] = thr;
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic bit m_remove(input int id);
    for (int i = 0; i < N; i++) begin
      if (m_act[i] && m_id[i] == id) begin
        m_act[i] = 0; m_arm[i] = 0;
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic void m_set(input int t);
    ntf_t e;
    int lvl;
    m_temp = t;
    for (int i = 0; i < N; i++) begin
      if (!m_act[i]) continue;
      lvl = (m_thr[i] > int'(HY)) ? m_thr[i] - int'(HY) : 0;
      e.id = m_id[i]; e.temp = t; e.kind = -1;
      if (!m_alm[i]) e.kind = 0;
      else if (!m_arm[i] && t >= m_thr[i]) begin e.kind = 1; m_arm[i] = 1; end
      else if (m_arm[i] && t < lvl) begin e.kind = 2; m_arm[i] = 0; end
      if (e.kind >= 0) exp_q.push_back(e);
    end
  endfunction

  // Offer one command at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send_cmd(input int op, input int id, input int data);
    int w = 0;
    while (!bus.cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready before command", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_id    = IW'(id);
    bus.cmd_data  = TW'(data);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  // Drain a sweep: mode 0 always ready, mode 1 random ready; first ntf stalled 'stall' cycles.
  task automatic collect(input int mode, input int stall, output int n, output int busy_cyc);
    bit hold = 0;
    bit rdy;
    int hid = 0, hkind = 0, htemp = 0;
    int guard = 0;
    n = 0;
    busy_cyc = 0;
    while (bus.busy && guard < 300) begin
      busy_cyc++;
      guard++;
      if (bus.cmd_ready) chk("cmd_ready while busy", bus.cmd_ready, 0);
      if (bus.ntf_valid) begin
        if (!hold) begin
          hold = 1; hid = bus.ntf_id; hkind = bus.ntf_kind; htemp = bus.ntf_temp;
          chk("ntf expected by model", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            chk("ntf_id", bus.ntf_id, exp_q[0].id);
            chk("ntf_kind", bus.ntf_kind, exp_q[0].kind);
            chk("ntf_temp", bus.ntf_temp, exp_q[0].temp);
          end
        end else begin
          chk("ntf_id stable", bus.ntf_id, hid);
          chk("ntf_kind stable", bus.ntf_kind, hkind);
          chk("ntf_temp stable", bus.ntf_temp, htemp);
        end
        if (stall > 0) begin
          rdy = 1'b0;
          stall--;
        end else begin
          rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        if (rdy) begin
          hold = 0;
          n++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        bus.ntf_ready = rdy;
      end else begin
        if (hold) chk("ntf_valid dropped without handshake", bus.ntf_valid, 1);
        hold = 0;
        bus.ntf_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    bus.ntf_ready = 1'b0;
    chk("sweep terminates", bus.busy, 0);
    chk("cmd_ready after sweep", bus.cmd_ready, 1);
    chk("notifications left undelivered", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_op(input int op, input int id, input int data, input int mode,
                       input int stall, output int err, output int n, output int busy_cyc);
    bit merr = 1'b0;
    case (op)
      0: merr = m_add(1'b0, id, data);
      1: merr = m_add(1'b1, id, data);
      2: merr = m_remove(id);
      default: m_set(data);
    endcase
    send_cmd(op, id, data);
    err = int'(bus.cmd_err);
    chk("cmd_err", bus.cmd_err, merr);
    chk("obs_count", bus.obs_count, m_count());
    chk("cur_temp", bus.cur_temp, m_temp);
    if (op == 3) begin
      chk("busy after set", bus.busy, 1);
      collect(mode, stall, n, busy_cyc);
    end else begin
      n = 0;
      busy_cyc = 0;
      @(negedge clk);
      chk("cmd_err single pulse", bus.cmd_err, 0);
      chk("cmd_ready stays after add/remove", bus.cmd_ready, 1);
    end
  endtask

  typedef struct {int op; int id; int data; int err; int cnt; int n;} vec_t;
  vec_t tbl[$];

  task automatic v(input int op, input int id, input int data, input int err, input int cnt,
                   input int n);
    vec_t t;
    t.op = op; t.id = id; t.data = data; t.err = err; t.cnt = cnt; t.n = n;
    tbl.push_back(t);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: got %0d checks expected completion", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int err, n, bc, k;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_id    = '0;
    bus.cmd_data  = '0;
    bus.ntf_ready = 1'b0;
    m_reset();

    // op, id, data, expected err, obs_count, notification count
    v(0, 1, 0, 0, 1, 0);       v(0, 2, 0, 0, 2, 0);       v(1, 16'hA1A2, 25, 0, 3, 0);
    v(3, 0, 20, 0, 3, 2);      v(3, 0, 30, 0, 3, 3);      v(3, 0, 24, 0, 3, 2);
    v(3, 0, 22, 0, 3, 3);      v(2, 1, 0, 0, 2, 0);       v(2, 2, 0, 0, 1, 0);
    v(2, 16'hA1A2, 0, 0, 0, 0);
    v(0, 1, 0, 0, 1, 0);       v(0, 2, 0, 0, 2, 0);       v(0, 3, 0, 0, 3, 0);
    v(0, 4, 0, 0, 4, 0);       v(0, 9, 0, 1, 4, 0);       v(2, 4, 0, 0, 3, 0);
    v(0, 3, 0, 1, 3, 0);       v(2, 16'h55, 0, 1, 3, 0);  v(2, 1, 0, 0, 2, 0);
    v(2, 2, 0, 0, 1, 0);       v(2, 3, 0, 0, 0, 0);       v(3, 0, 40, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset cmd_ready", bus.cmd_ready, 1);
    chk("reset busy", bus.busy, 0);
    chk("reset obs_count", bus.obs_count, 0);
    chk("reset cur_temp", bus.cur_temp, 0);
    chk("reset ntf_valid", bus.ntf_valid, 0);
    chk("reset cmd_err", bus.cmd_err, 0);

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].id, tbl[i].data, 1, 0, err, n, bc);
      chk($sformatf("vec%0d err", i), err, tbl[i].err);
      chk($sformatf("vec%0d obs_count", i), bus.obs_count, tbl[i].cnt);
      chk($sformatf("vec%0d ntf count", i), n, tbl[i].n);
      if (tbl[i].op == 3) chk($sformatf("vec%0d cur_temp", i), bus.cur_temp, tbl[i].data);
      if (tbl[i].op == 3 && tbl[i].n == 0) chk($sformatf("vec%0d busy cycles", i), bc, N);
    end

    // Back-pressure: first notification stalled for 5 cycles.
    do_op(0, 1, 0, 0, 0, err, n, bc);
    do_op(0, 2, 0, 0, 0, err, n, bc);
    do_op(1, 16'hA1A2, 25, 0, 0, err, n, bc);
    do_op(3, 0, 30, 0, 5, err, n, bc);
    chk("stalled sweep ntf count", n, 3);

    // Reset while a notification is waiting in EMIT.
    send_cmd(3, 0, 30);
    k = 0;
    while (!bus.ntf_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("reached EMIT before reset", bus.ntf_valid, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset ntf_valid", bus.ntf_valid, 0);
    chk("post-reset obs_count", bus.obs_count, 0);
    chk("post-reset cmd_ready", bus.cmd_ready, 1);
    chk("post-reset busy", bus.busy, 0);
    chk("post-reset cur_temp", bus.cur_temp, 0);
    chk("post-reset ntf_id", bus.ntf_id, 0);
    chk("post-reset ntf_kind", bus.ntf_kind, 0);
    chk("post-reset ntf_temp", bus.ntf_temp, 0);
    m_reset();
    do_op(3, 0, 30, 1, 0, err, n, bc);
    chk("post-reset sweep ntf count", n, 0);
    chk("post-reset sweep busy cycles", bc, N);

    // Random commands against the model.
    for (int it = 0; it < 300; it++) begin
      int r, op;
      r = $urandom_range(0, 9);
      op = (r < 3) ? 0 : (r < 5) ? 1 : (r < 7) ? 2 : 3;
      do_op(op, $urandom_range(1, 6), $urandom_range(0, 60), 1, $urandom_range(0, 2),
            err, n, bc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
